// File: rtl/wash_display_scan_if.sv
// Panel bus for the washing-machine display: phase code and BCD digits in,
// multiplexed common-anode digit enables and active-low segments out.
interface wash_display_scan_if;
    logic [2:0] state_display;
    logic [3:0] seg3;
    logic [3:0] seg2;
    logic [3:0] seg1;
    logic [3:0] seg0;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;

    // Upstream timer/controller side: drives digits and phase, observes the panel lines.
    modport master (
        output state_display, seg3, seg2, seg1, seg0,
        input  an_n, seg_n, dp_n
    );

    // Display driver side.
    modport slave (
        input  state_display, seg3, seg2, seg1, seg0,
        output an_n, seg_n, dp_n
    );
endinterface

// File: rtl/wash_display_scan.sv
// Time-multiplexed 4-digit seven-segment driver with per-frame snapshot,
// minutes leading-zero blanking, idle dashes and alarm-phase whole-display blink.
module wash_display_scan #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 250
) (
    input  logic                clk,
    input  logic                reset,
    wash_display_scan_if.slave  bus
);

    localparam int unsigned CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned DIG_W   = 4;
    localparam int unsigned SNAP_W  = 4 * DIG_W;

    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_ALARM = 3'b000;

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Standard active-low {g,f,e,d,c,b,a} patterns; non-decimal codes show a dash.
    function automatic logic [6:0] decode_bcd(input logic [DIG_W-1:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_DASH;
        endcase
        return p;
    endfunction

    function automatic logic [DIG_W-1:0] pick_digit(input logic [SNAP_W-1:0] snap,
                                                    input logic [1:0]        pos);
        logic [DIG_W-1:0] d;
        case (pos)
            2'd0:    d = snap[3:0];
            2'd1:    d = snap[7:4];
            2'd2:    d = snap[11:8];
            default: d = snap[15:12];
        endcase
        return d;
    endfunction

    logic [CNT_W-1:0]   scan_cnt,    scan_cnt_d;
    logic [1:0]         idx,         idx_d;
    logic [SNAP_W-1:0]  snap_digits, snap_digits_d;
    logic [2:0]         snap_state,  snap_state_d;
    logic [FRAME_W-1:0] frame_cnt,   frame_cnt_d;
    logic               blink_on,    blink_on_d;
    logic               frame_lit,   frame_lit_d;
    logic [3:0]         an_q,        an_d;
    logic [6:0]         seg_q,       seg_d;
    logic               dp_q,        dp_d;

    logic               tick;
    logic [SNAP_W-1:0]  eff_digits;
    logic [2:0]         eff_state;
    logic               eff_lit;
    logic [DIG_W-1:0]   cur_digit;

    // Next-state: scan counter, digit index, frame snapshot, blink and decoded outputs.
    always_comb begin
        scan_cnt_d    = scan_cnt;
        idx_d         = idx;
        snap_digits_d = snap_digits;
        snap_state_d  = snap_state;
        frame_cnt_d   = frame_cnt;
        blink_on_d    = blink_on;
        frame_lit_d   = frame_lit;
        an_d          = an_q;
        seg_d         = seg_q;
        dp_d          = dp_q;
        eff_digits    = snap_digits;
        eff_state     = snap_state;
        eff_lit       = frame_lit;
        cur_digit     = '0;

        tick = (scan_cnt == CNT_W'(SCAN_DIV - 1));

        if (tick) begin
            scan_cnt_d = '0;
            idx_d      = idx + 2'd1;

            // Frame start: the new snapshot and lit decision govern all four digits.
            if (idx == 2'd3) begin
                eff_digits    = {bus.seg3, bus.seg2, bus.seg1, bus.seg0};
                eff_state     = bus.state_display;
                snap_digits_d = eff_digits;
                snap_state_d  = eff_state;
                if (eff_state == ST_ALARM) begin
                    // Lit state follows blink_on as it stood before this frame's update,
                    // so the first BLINK_DIV alarm frames are visible.
                    eff_lit = blink_on;
                    if (frame_cnt == FRAME_W'(BLINK_DIV - 1)) begin
                        frame_cnt_d = '0;
                        blink_on_d  = ~blink_on;
                    end else begin
                        frame_cnt_d = frame_cnt + FRAME_W'(1);
                    end
                end else begin
                    eff_lit     = 1'b1;
                    frame_cnt_d = '0;
                    blink_on_d  = 1'b1;
                end
                frame_lit_d = eff_lit;
            end

            cur_digit = pick_digit(eff_digits, idx_d);

            if (eff_state == ST_IDLE) begin
                seg_d = SEG_DASH;
                dp_d  = 1'b1;
            end else if ((idx_d == 2'd3) && (eff_digits[15:12] == 4'd0)) begin
                seg_d = SEG_OFF;
                dp_d  = 1'b1;
            end else begin
                seg_d = decode_bcd(cur_digit);
                dp_d  = ~idx_d[0];
            end

            an_d = eff_lit ? ~(4'b0001 << idx_d) : 4'b1111;
        end else begin
            scan_cnt_d = scan_cnt + CNT_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt    <= '0;
            idx         <= 2'd3;
            snap_digits <= '0;
            snap_state  <= ST_IDLE;
            frame_cnt   <= '0;
            blink_on    <= 1'b1;
            frame_lit   <= 1'b1;
            an_q        <= 4'b1111;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            scan_cnt    <= scan_cnt_d;
            idx         <= idx_d;
            snap_digits <= snap_digits_d;
            snap_state  <= snap_state_d;
            frame_cnt   <= frame_cnt_d;
            blink_on    <= blink_on_d;
            frame_lit   <= frame_lit_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.an_n  = an_q;
    assign bus.seg_n = seg_q;
    assign bus.dp_n  = dp_q;

endmodule
